operand_register_file: RTL

OPERAND_REGISTER_FILE -- requirements
Module: operand_register_file

---
 rtl/operand_register_file_pkg.sv | 18 +
 rtl/operand_register_file_read_port.sv | 51 +++++
 rtl/operand_register_file.sv | 84 ++++++++
 3 files changed

// File: rtl/operand_register_file_pkg.sv
// Shared CPU constants for the operand register file: select width, zero register and status flag layout.
package operand_register_file_pkg;

  localparam int SEL_W        = 5;
  localparam int REG_COUNT    = 32;
  localparam int ZERO_REG_IDX = 31;

  // Status flags are packed as {V,C,Z,N}.
  localparam int STATUS_W = 4;
  localparam int STATUS_V = 3;
  localparam int STATUS_C = 2;
  localparam int STATUS_Z = 1;
  localparam int STATUS_N = 0;

  typedef logic [SEL_W-1:0]    sel_t;
  typedef logic [STATUS_W-1:0] status_t;

endpackage

// File: rtl/operand_register_file_read_port.sv
// One registered operand read port: zero-register forcing and optional write bypass.
// Bypass of same-edge writes is enabled by defining OPERAND_REGISTER_FILE_BYPASS_EN.
module regfile_read_port
  import operand_register_file_pkg::*;
#(
  parameter int   DATA_WIDTH = 64,
  parameter sel_t ZERO_SEL   = sel_t'(ZERO_REG_IDX)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  sel_t                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_wr_en,
  input  sel_t                  i_wr_sel,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_q
);

`ifdef OPERAND_REGISTER_FILE_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_next;
  logic [DATA_WIDTH-1:0] r_q;

  assign w_hit = i_wr_en && (i_wr_sel == i_sel) && (i_sel != ZERO_SEL);

  // Zero forcing wins over everything; otherwise a same-edge write may be forwarded.
  always_comb begin
    w_next = i_rd_data;
    if (i_sel == ZERO_SEL) begin
      w_next = '0;
    end else if (BYPASS_EN && w_hit) begin
      w_next = i_wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/operand_register_file.sv
// 32-entry register file with two registered operand outputs and a latched ALU status word.
// Optional feature macro: OPERAND_REGISTER_FILE_BYPASS_EN (forward same-edge writes to A/B).
module operand_register_file
  import operand_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = ZERO_REG_IDX
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [SEL_W-1:0]      SA,
  input  logic [SEL_W-1:0]      SB,
  input  logic [SEL_W-1:0]      DA,
  input  logic                  W,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  SL,
  input  logic [STATUS_W-1:0]   status_in,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [STATUS_W-1:0]   status
);

  localparam sel_t ZERO_SEL = sel_t'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  status_t               r_status;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  // The zero register is never written, so its storage stays at its reset value.
  assign w_wr_en = W && (DA != ZERO_SEL);
  assign w_rd_a  = r_regs[SA];
  assign w_rd_b  = r_regs[SB];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[DA] <= D;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_status <= '0;
    end else if (SL) begin
      r_status <= status_in;
    end
  end

  assign status = r_status;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ZERO_SEL   (ZERO_SEL)
  ) u_port_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_sel     (SA),
    .i_rd_data (w_rd_a),
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (DA),
    .i_wr_data (D),
    .o_q       (A)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ZERO_SEL   (ZERO_SEL)
  ) u_port_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_sel     (SB),
    .i_rd_data (w_rd_b),
    .i_wr_en   (w_wr_en),
    .i_wr_sel  (DA),
    .i_wr_data (D),
    .o_q       (B)
  );

endmodule
